// File: rtl/ysyx_22050854_exe_stage_reg_if.sv
// ID/EXE pipeline-register bus.
// Groups every signal between ID, the forwarding sources, the ALU/MEM
// back-pressure and the EXE register outputs.
//   master : the side that drives ID fields, forwarding, alu_busy, mem_ready, flush
//   slave  : the EXE register itself (drives id_ready and the registered outputs)
interface ysyx_22050854_exe_stage_reg_if #(
    parameter int XLEN   = 64,
    parameter int RFADDR = 5
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [XLEN-1:0]   id_pc;
    logic [RFADDR-1:0] id_rs1;
    logic [RFADDR-1:0] id_rs2;
    logic [RFADDR-1:0] id_rd;
    logic              id_rf_wen;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm;
    logic              id_src1_pc;
    logic              id_src2_imm;
    logic [3:0]        id_ALUctr;
    logic [3:0]        id_MULctr;
    logic [2:0]        id_ALUext;
    logic              exe_fwd_valid;
    logic [RFADDR-1:0] exe_fwd_rd;
    logic [XLEN-1:0]   exe_fwd_data;
    logic              mem_fwd_valid;
    logic [RFADDR-1:0] mem_fwd_rd;
    logic [XLEN-1:0]   mem_fwd_data;
    logic              alu_busy;
    logic              mem_ready;
    logic              EXEreg_valid;
    logic [3:0]        ALUctr;
    logic [3:0]        MULctr;
    logic [2:0]        ALUext;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   exe_rs2_data;
    logic [XLEN-1:0]   exe_pc;
    logic [RFADDR-1:0] exe_rd;
    logic              exe_rf_wen;
    logic              exe_fire;

    modport master (
        output flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rf_wen,
               id_rs1_data, id_rs2_data, id_imm, id_src1_pc, id_src2_imm,
               id_ALUctr, id_MULctr, id_ALUext,
               exe_fwd_valid, exe_fwd_rd, exe_fwd_data,
               mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
               alu_busy, mem_ready,
        input  id_ready, EXEreg_valid, ALUctr, MULctr, ALUext, src1, src2,
               exe_rs2_data, exe_pc, exe_rd, exe_rf_wen, exe_fire
    );

    modport slave (
        input  flush, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rf_wen,
               id_rs1_data, id_rs2_data, id_imm, id_src1_pc, id_src2_imm,
               id_ALUctr, id_MULctr, id_ALUext,
               exe_fwd_valid, exe_fwd_rd, exe_fwd_data,
               mem_fwd_valid, mem_fwd_rd, mem_fwd_data,
               alu_busy, mem_ready,
        output id_ready, EXEreg_valid, ALUctr, MULctr, ALUext, src1, src2,
               exe_rs2_data, exe_pc, exe_rd, exe_rf_wen, exe_fire
    );
endinterface

// File: rtl/ysyx_22050854_exe_stage_reg.sv
// ID/EXE pipeline register feeding the execute-stage ALU.
// Captures a decoded instruction over the id_valid/id_ready handshake,
// resolves rs1/rs2 bypass (EXE source over MEM source) at capture time,
// selects PC/immediate operands, holds while the ALU is busy or MEM stalls,
// and drops the entry on flush.
// Ports:
//   clock : clock
//   reset : asynchronous active-low reset (clears valid and all data)
//   bus   : slave side of ysyx_22050854_exe_stage_reg_if (ID fields,
//           forwarding, back-pressure in; registered EXE fields out)
module ysyx_22050854_exe_stage_reg #(
    parameter int XLEN   = 64,
    parameter int RFADDR = 5
) (
    input  logic clock,
    input  logic reset,
    ysyx_22050854_exe_stage_reg_if.slave bus
);

    // Bypass priority: x0 is hardwired zero, then the younger EXE result,
    // then the MEM result, then the regfile read.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RFADDR-1:0] rs,
        input logic [XLEN-1:0]   rf_data,
        input logic              a_valid,
        input logic [RFADDR-1:0] a_rd,
        input logic [XLEN-1:0]   a_data,
        input logic              b_valid,
        input logic [RFADDR-1:0] b_rd,
        input logic [XLEN-1:0]   b_data
    );
        if (rs == '0)                    return '0;
        else if (a_valid && (a_rd == rs)) return a_data;
        else if (b_valid && (b_rd == rs)) return b_data;
        else                              return rf_data;
    endfunction

    logic              valid_p1;
    logic [3:0]        alu_ctr_p1;
    logic [3:0]        mul_ctr_p1;
    logic [2:0]        alu_ext_p1;
    logic [XLEN-1:0]   src1_p1;
    logic [XLEN-1:0]   src2_p1;
    logic [XLEN-1:0]   rs2_data_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [RFADDR-1:0] rd_p1;
    logic              rf_wen_p1;

    logic              fire_p1;
    logic              ready_p0;
    logic              capture_p0;
    logic [XLEN-1:0]   fwd_rs1_p0;
    logic [XLEN-1:0]   fwd_rs2_p0;
    logic [XLEN-1:0]   src1_p0;
    logic [XLEN-1:0]   src2_p0;

    // p0: ID-side operand resolution and handshake
    always_comb begin
        fire_p1    = valid_p1 & ~bus.alu_busy & bus.mem_ready;
        // flush blocks capture even when the slot is free
        ready_p0   = ~bus.flush & (~valid_p1 | fire_p1);
        capture_p0 = bus.id_valid & ready_p0;
        fwd_rs1_p0 = fwd_sel(bus.id_rs1, bus.id_rs1_data,
                             bus.exe_fwd_valid, bus.exe_fwd_rd, bus.exe_fwd_data,
                             bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data);
        fwd_rs2_p0 = fwd_sel(bus.id_rs2, bus.id_rs2_data,
                             bus.exe_fwd_valid, bus.exe_fwd_rd, bus.exe_fwd_data,
                             bus.mem_fwd_valid, bus.mem_fwd_rd, bus.mem_fwd_data);
        src1_p0    = bus.id_src1_pc  ? bus.id_pc  : fwd_rs1_p0;
        src2_p0    = bus.id_src2_imm ? bus.id_imm : fwd_rs2_p0;
    end

    // p1: EXE register (control)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_p1 <= 1'b0;
        end else if (capture_p0) begin
            valid_p1 <= 1'b1;
        end else if (fire_p1 || bus.flush) begin
            valid_p1 <= 1'b0;
        end
    end

    // p1: EXE register (data) -- only loads on capture, so operands stay
    // frozen for the whole alu_busy / mem_ready stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_ctr_p1  <= '0;
            mul_ctr_p1  <= '0;
            alu_ext_p1  <= '0;
            src1_p1     <= '0;
            src2_p1     <= '0;
            rs2_data_p1 <= '0;
            pc_p1       <= '0;
            rd_p1       <= '0;
            rf_wen_p1   <= 1'b0;
        end else if (capture_p0) begin
            alu_ctr_p1  <= bus.id_ALUctr;
            mul_ctr_p1  <= bus.id_MULctr;
            alu_ext_p1  <= bus.id_ALUext;
            src1_p1     <= src1_p0;
            src2_p1     <= src2_p0;
            rs2_data_p1 <= fwd_rs2_p0;
            pc_p1       <= bus.id_pc;
            rd_p1       <= bus.id_rd;
            rf_wen_p1   <= bus.id_rf_wen;
        end
    end

    assign bus.id_ready     = ready_p0;
    assign bus.exe_fire     = fire_p1;
    assign bus.EXEreg_valid = valid_p1;
    assign bus.ALUctr       = alu_ctr_p1;
    assign bus.MULctr       = mul_ctr_p1;
    assign bus.ALUext       = alu_ext_p1;
    assign bus.src1         = src1_p1;
    assign bus.src2         = src2_p1;
    assign bus.exe_rs2_data = rs2_data_p1;
    assign bus.exe_pc       = pc_p1;
    assign bus.exe_rd       = rd_p1;
    assign bus.exe_rf_wen   = rf_wen_p1;

endmodule

// File: tb/tb_ysyx_22050854_exe_stage_reg.sv
// Directed bench for the ID/EXE register with a scoreboard of expected
// EXE contents, pushed on capture and retired on exe_fire or flush.
module tb_ysyx_22050854_exe_stage_reg;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_22050854_exe_stage_reg_if #(.XLEN(64), .RFADDR(5)) bus ();

    ysyx_22050854_exe_stage_reg #(.XLEN(64), .RFADDR(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] src1;
        logic [63:0] src2;
        logic [63:0] rs2d;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic [3:0]  aluctr;
        logic [3:0]  mulctr;
        logic [2:0]  aluext;
    } exp_t;

    exp_t q[$];
    logic mv = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mfwd(input logic [4:0] rs, input logic [63:0] rfd);
        if (rs == 5'd0) return 64'd0;
        if (bus.exe_fwd_valid && bus.exe_fwd_rd == rs) return bus.exe_fwd_data;
        if (bus.mem_fwd_valid && bus.mem_fwd_rd == rs) return bus.mem_fwd_data;
        return rfd;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e.src1   = bus.id_src1_pc  ? bus.id_pc  : mfwd(bus.id_rs1, bus.id_rs1_data);
        e.src2   = bus.id_src2_imm ? bus.id_imm : mfwd(bus.id_rs2, bus.id_rs2_data);
        e.rs2d   = mfwd(bus.id_rs2, bus.id_rs2_data);
        e.pc     = bus.id_pc;
        e.rd     = bus.id_rd;
        e.wen    = bus.id_rf_wen;
        e.aluctr = bus.id_ALUctr;
        e.mulctr = bus.id_MULctr;
        e.aluext = bus.id_ALUext;
        return e;
    endfunction

    task automatic check_head();
        exp_t e;
        e = q[0];
        chk("src1",     bus.src1,         e.src1);
        chk("src2",     bus.src2,         e.src2);
        chk("rs2_data", bus.exe_rs2_data, e.rs2d);
        chk("pc",       bus.exe_pc,       e.pc);
        chk("rd",       64'(bus.exe_rd),     64'(e.rd));
        chk("rf_wen",   64'(bus.exe_rf_wen), 64'(e.wen));
        chk("ALUctr",   64'(bus.ALUctr),     64'(e.aluctr));
        chk("MULctr",   64'(bus.MULctr),     64'(e.mulctr));
        chk("ALUext",   64'(bus.ALUext),     64'(e.aluext));
    endtask

    // One clock: inputs already driven after a negedge; check, update model, advance.
    task automatic step();
        logic efire, erdy, cap;
        #1;
        efire = mv & ~bus.alu_busy & bus.mem_ready;
        erdy  = ~bus.flush & (~mv | efire);
        cap   = bus.id_valid & erdy;
        chk("EXEreg_valid", 64'(bus.EXEreg_valid), 64'(mv));
        chk("exe_fire",     64'(bus.exe_fire),     64'(efire));
        chk("id_ready",     64'(bus.id_ready),     64'(erdy));
        if (mv) begin
            if (q.size() == 0) chk("queue_empty", 64'd1, 64'd0);
            else check_head();
        end
        if (mv && (efire || bus.flush) && q.size() != 0) void'(q.pop_front());
        if (cap) q.push_back(model());
        if (cap) mv = 1'b1;
        else if (efire || bus.flush) mv = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic issue(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [63:0] d1, input logic [63:0] d2,
                         input logic [63:0] imm, input logic s1pc, input logic s2imm,
                         input logic [3:0] aluctr, input logic [3:0] mulctr, input logic [2:0] ext);
        bus.id_valid    = 1'b1;
        bus.id_pc       = pc;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.id_rf_wen   = (rd != 5'd0);
        bus.id_rs1_data = d1;
        bus.id_rs2_data = d2;
        bus.id_imm      = imm;
        bus.id_src1_pc  = s1pc;
        bus.id_src2_imm = s2imm;
        bus.id_ALUctr   = aluctr;
        bus.id_MULctr   = mulctr;
        bus.id_ALUext   = ext;
    endtask

    task automatic set_fwd(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                           input logic bv, input logic [4:0] brd, input logic [63:0] bd);
        bus.exe_fwd_valid = av;
        bus.exe_fwd_rd    = ard;
        bus.exe_fwd_data  = ad;
        bus.mem_fwd_valid = bv;
        bus.mem_fwd_rd    = brd;
        bus.mem_fwd_data  = bd;
    endtask

    initial begin
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.alu_busy = 1'b0;
        bus.mem_ready = 1'b1;
        set_fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        issue(64'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
        bus.id_valid = 1'b0;

        // reset state
        #1;
        chk("rst_valid", 64'(bus.EXEreg_valid), 64'd0);
        chk("rst_src1",  bus.src1, 64'd0);
        chk("rst_src2",  bus.src2, 64'd0);
        chk("rst_pc",    bus.exe_pc, 64'd0);
        chk("rst_rs2d",  bus.exe_rs2_data, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        step();

        // add with both sources matching rs1: EXE source wins
        set_fwd(1'b1, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
        issue(64'h1000, 5'd5, 5'd6, 5'd7, 64'h99, 64'h7, 64'h0, 1'b0, 1'b0, 4'd1, 4'd0, 3'd0);
        step();
        bus.id_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("add_src1", bus.src1, 64'h11);
        chk("add_src2", bus.src2, 64'h7);
        step();

        // rs1=0 with an EXE forward aimed at x0 still reads zero
        set_fwd(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0);
        issue(64'h1004, 5'd0, 5'd6, 5'd8, 64'h33, 64'h7, 64'h0, 1'b0, 1'b0, 4'd1, 4'd0, 3'd0);
        step();
        bus.id_valid = 1'b0;
        #1;
        chk("x0_src1", bus.src1, 64'd0);
        step();

        // MEM-only forward on rs2
        set_fwd(1'b0, 5'd6, 64'h44, 1'b1, 5'd6, 64'h22);
        issue(64'h1008, 5'd3, 5'd6, 5'd9, 64'h3, 64'h7, 64'h0, 1'b0, 1'b0, 4'd2, 4'd0, 3'd1);
        step();
        bus.id_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        #1;
        chk("memfwd_src2", bus.src2, 64'h22);
        step();

        // mul held 65 cycles by alu_busy while ID offers the next instruction
        issue(64'h100c, 5'd1, 5'd2, 5'd10, 64'h1234, 64'h5678, 64'h0, 1'b0, 1'b0, 4'd0, 4'd1, 3'd2);
        step();
        issue(64'h1010, 5'd2, 5'd3, 5'd11, 64'h2, 64'h3, 64'h0, 1'b0, 1'b0, 4'd3, 4'd0, 3'd0);
        bus.alu_busy = 1'b1;
        for (int i = 0; i < 65; i++) step();
        chk("mul_src1_held", bus.src1, 64'h1234);
        bus.alu_busy = 1'b0;
        #1;
        chk("mul_release_fire", 64'(bus.exe_fire), 64'd1);
        chk("mul_release_ready", 64'(bus.id_ready), 64'd1);
        step();
        bus.id_valid = 1'b0;
        #1;
        chk("next_pc", bus.exe_pc, 64'h1010);
        step();

        // auipc: PC and immediate operands
        issue(64'h80000000, 5'd4, 5'd5, 5'd12, 64'hdead, 64'hbeef, 64'h1000, 1'b1, 1'b1, 4'd0, 4'd0, 3'd0);
        step();
        bus.id_valid = 1'b0;
        #1;
        chk("auipc_src1", bus.src1, 64'h80000000);
        chk("auipc_src2", bus.src2, 64'h1000);
        step();

        // flush during a busy div with ID offering an instruction
        issue(64'h2000, 5'd1, 5'd2, 5'd13, 64'h64, 64'h7, 64'h0, 1'b0, 1'b0, 4'd0, 4'd5, 3'd2);
        step();
        issue(64'h2004, 5'd1, 5'd2, 5'd14, 64'h1, 64'h1, 64'h0, 1'b0, 1'b0, 4'd1, 4'd0, 3'd0);
        bus.alu_busy = 1'b1;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.alu_busy = 1'b0;
        bus.id_valid = 1'b0;
        #1;
        chk("flush_valid", 64'(bus.EXEreg_valid), 64'd0);
        chk("flush_pc_held", bus.exe_pc, 64'h2000);
        step();

        // stream of 4, then a 2-cycle mem_ready stall, then resume
        for (int i = 0; i < 4; i++) begin
            issue(64'h3000 + 64'(4 * i), 5'(i + 1), 5'(i + 2), 5'(i + 16),
                  64'(i * 3 + 1), 64'(i * 5 + 2), 64'h0, 1'b0, 1'b0, 4'(i), 4'd0, 3'd0);
            step();
        end
        issue(64'h3010, 5'd7, 5'd8, 5'd20, 64'h70, 64'h80, 64'h0, 1'b0, 1'b0, 4'd9, 4'd0, 3'd0);
        bus.mem_ready = 1'b0;
        step();
        step();
        bus.mem_ready = 1'b1;
        step();
        bus.id_valid = 1'b0;
        #1;
        chk("resume_pc", bus.exe_pc, 64'h3010);
        step();
        step();

        // reset asserted mid-stall with a live entry
        issue(64'h4000, 5'd1, 5'd2, 5'd21, 64'haa, 64'hbb, 64'h0, 1'b0, 1'b0, 4'd1, 4'd0, 3'd0);
        step();
        bus.id_valid = 1'b0;
        bus.alu_busy = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.EXEreg_valid), 64'd0);
        chk("async_rst_src1", bus.src1, 64'd0);
        chk("async_rst_src2", bus.src2, 64'd0);
        mv = 1'b0;
        q.delete();
        bus.alu_busy = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        issue(64'h5000, 5'd9, 5'd10, 5'd22, 64'h9, 64'ha, 64'h0, 1'b0, 1'b0, 4'd2, 4'd0, 3'd0);
        step();
        bus.id_valid = 1'b0;
        #1;
        chk("post_rst_src1", bus.src1, 64'h9);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050854_exe_stage_reg.md
Name: ysyx_22050854_exe_stage_reg

Overview:
ID/EXE pipeline register that feeds the execute-stage ALU (ALUctr/MULctr/ALUext/src1/src2/EXEreg_valid).
- Accepts decoded instructions from ID over a valid/ready handshake.
- Resolves operand bypass from two forwarding sources at capture time and selects immediate/PC operands.
- Holds the instruction while the ALU reports alu_busy (multi-cycle mul/div) or MEM is not ready.
- Discards it on flush.

Parameters:
XLEN, 64, datapath width
RFADDR, 5, register index width

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-low reset (0 = reset)
flush  in  1  kill EXE contents and block capture this cycle (branch redirect/trap)
id_valid  in  1  ID holds a valid decoded instruction
id_ready  out  1  EXE register can accept this cycle
id_pc  in  XLEN  instruction PC
id_rs1  in  RFADDR  source 1 index
id_rs2  in  RFADDR  source 2 index
id_rd  in  RFADDR  destination index
id_rf_wen  in  1  instruction writes rd
id_rs1_data  in  XLEN  regfile read data 1
id_rs2_data  in  XLEN  regfile read data 2
id_imm  in  XLEN  sign-extended immediate
id_src1_pc  in  1  src1 = PC (auipc/jal)
id_src2_imm  in  1  src2 = imm
id_ALUctr  in  4  ALU op
id_MULctr  in  4  mul/div op
id_ALUext  in  3  result select
exe_fwd_valid  in  1  forwarding source A valid (higher priority)
exe_fwd_rd  in  RFADDR  source A rd
exe_fwd_data  in  XLEN  source A data
mem_fwd_valid  in  1  forwarding source B valid
mem_fwd_rd  in  RFADDR  source B rd
mem_fwd_data  in  XLEN  source B data
alu_busy  in  1  ALU multi-cycle op not finished
mem_ready  in  1  MEM stage can accept
EXEreg_valid  out  1  register holds live instruction
ALUctr  out  4  registered op
MULctr  out  4  registered mul/div op
ALUext  out  3  registered result select
src1  out  XLEN  ALU operand 1
src2  out  XLEN  ALU operand 2
exe_rs2_data  out  XLEN  forwarded rs2 value (store data)
exe_pc  out  XLEN  registered PC
exe_rd  out  RFADDR  registered rd
exe_rf_wen  out  1  registered write enable
exe_fire  out  1  instruction leaves EXE this cycle

Behaviour:
- Reset (reset=0, async): EXEreg_valid=0. All data outputs are 0, including ALUctr/MULctr/ALUext/src1/src2/exe_pc/exe_rd/exe_rf_wen/exe_rs2_data.
- exe_fire = EXEreg_valid & !alu_busy & mem_ready (combinational).
- id_ready = !flush & (!EXEreg_valid | exe_fire) (combinational).
- Capture when id_valid & id_ready: all fields register on the rising edge and EXEreg_valid becomes 1.
- Else if exe_fire or flush: EXEreg_valid becomes 0. Data registers hold their value.
- Otherwise (stall): every register holds.
- Forwarding is evaluated at capture only, per source rsN:
  - rsN==0 → 0.
  - else exe_fwd_valid & exe_fwd_rd==rsN → exe_fwd_data.
  - else mem_fwd_valid & mem_fwd_rd==rsN → mem_fwd_data.
  - else id_rsN_data.
- Operand select:
  - src1 = id_src1_pc ? id_pc : fwd_rs1.
  - src2 = id_src2_imm ? id_imm : fwd_rs2.
  - exe_rs2_data = fwd_rs2 always.
- Load-use hazards are resolved by ID (id_valid withheld). This block does no hazard detection.
- Flush has priority over capture and over stall. A flush during alu_busy drops EXEreg_valid next cycle; the ALU sees EXEreg_valid=0 and abandons the op.
- The registered outputs are stable for the whole stall. alu_busy must never see src changes mid-operation.
- Single-entry, no bubble: back-to-back capture every cycle while exe_fire=1.
- The EXEreg_valid=1 → exe_fire path has zero added latency; entry-to-ALU latency is 1 cycle.

Test Plan:
- Reset asserted mid-stall with EXEreg_valid=1 → EXEreg_valid=0 immediately (async), src1=src2=0; first capture after release works.
- Issue add with rs1=5, rs2=6, exe_fwd(rd=5, data=0x11), mem_fwd(rd=5, data=0x22), rs2_data=0x7 → src1=0x11, src2=0x7. Repeat with rs1=0 and exe_fwd_rd=0 → src1=0.
- Issue mul; hold alu_busy=1 for 65 cycles while id_valid=1 → id_ready=0, src1/src2 unchanged throughout. When alu_busy drops, exe_fire=1 and the next instruction is captured the same edge.
- auipc with id_src1_pc=1, id_pc=0x80000000, id_src2_imm=1, imm=0x1000 → src1=0x80000000, src2=0x1000.
- flush=1 while id_valid=1 and a div is in progress → id_ready=0, nothing captured, EXEreg_valid=0 next cycle.
- Stream 4 instructions with mem_ready=1, alu_busy=0 → one exe_fire per cycle, no bubbles. Drop mem_ready for 2 cycles → hold, then resume in order.
